and8_core: RTL and testbench

8-input AND reduction block with registered diagnostic outputs. Drives `b` high only when all eight bits of `a` are 1. It also reports how many input bits are 0 and where the lowest 0 is. The block is the golden reference for post-route equivalence checks of the `and8` netlist, and is used as a leaf gate in control logic.

---
 rtl/and8_core.sv | 48 ++++
 tb/tb_and8_core.sv | 91 +++++++++
 2 files changed

// File: rtl/and8_core.sv
// and8_core: 8-input AND reduction with registered zero-count, lowest-zero index and all-ones diagnostics.
// Ports: clk, rst (sync, active-high); a[7:0] operand; b = &a;
//        zero_cnt[3:0] zeros in a; zero_idx[2:0] lowest zero bit (0 if none); all_ones registered &a.
// Define AND8_REG_OUT_EN to drive b from a flop (1-cycle latency, equals all_ones).
module and8_core (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  output logic       b,
  output logic [3:0] zero_cnt,
  output logic [2:0] zero_idx,
  output logic       all_ones
);
  logic [3:0] cnt_d, cnt_q;
  logic [2:0] idx_d, idx_q;
  logic       ones_d, ones_q;
  // Scanning from the top down leaves the lowest zero's index in idx_d.
  always_comb begin
    cnt_d = 4'd0;
    idx_d = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      idx_d = a[i] ? idx_d : 3'(i);
      cnt_d = cnt_d + {3'd0, ~a[i]};
    end
    ones_d = &a;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 4'd0;
      idx_q  <= 3'd0;
      ones_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      ones_q <= ones_d;
    end
  end
  assign zero_cnt = cnt_q;
  assign zero_idx = idx_q;
  assign all_ones = ones_q;
`ifdef AND8_REG_OUT_EN
  logic b_q;
  always_ff @(posedge clk) b_q <= rst ? 1'b0 : ones_d;
  assign b = b_q;
`else
  assign b = &a;
`endif
endmodule

// File: tb/tb_and8_core.sv
// tb_and8_core: scoreboard bench for and8_core with randomized stimulus and a reference model.
module tb_and8_core;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a = 8'hFF;
  logic       b;
  logic [3:0] zero_cnt;
  logic [2:0] zero_idx;
  logic       all_ones;
  int checks = 0;
  int passed = 0;
  typedef struct packed {
    logic [3:0] cnt;
    logic [2:0] idx;
    logic       ones;
    logic       b;
  } exp_t;
  exp_t sb[$];
  and8_core dut (
    .clk(clk), .rst(rst), .a(a), .b(b),
    .zero_cnt(zero_cnt), .zero_idx(zero_idx), .all_ones(all_ones)
  );
  always #5 clk = ~clk;
  function automatic exp_t model(input logic r, input logic [7:0] v);
    exp_t e;
    logic [7:0] nz, lsb;
    nz    = ~v;
    lsb   = nz & (~nz + 8'd1);
    e.cnt = r ? 4'd0 : 4'(8 - $countones(v));
    e.idx = r ? 3'd0 : 3'($clog2(lsb));
    e.ones = r ? 1'b0 : (v == 8'hFF);
`ifdef AND8_REG_OUT_EN
    e.b = e.ones;
`else
    e.b = (v == 8'hFF);
`endif
    return e;
  endfunction
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
  endtask
  task automatic step(input logic r, input logic [7:0] v, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst = r;
      a = v;
      sb.push_back(model(r, v));
`ifndef AND8_REG_OUT_EN
      #1 check("b_comb", {7'd0, b}, {7'd0, v == 8'hFF});
`endif
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("zero_cnt", {4'd0, zero_cnt}, {4'd0, e.cnt});
        check("zero_idx", {5'd0, zero_idx}, {5'd0, e.idx});
        check("all_ones", {7'd0, all_ones}, {7'd0, e.ones});
        check("b_sync", {7'd0, b}, {7'd0, e.b});
      end
    end
  end
  initial begin
    logic [7:0] v;
    step(1'b1, 8'hFF, 2);
    for (int k = 0; k < 8; k++) begin
      v = 8'((9'd1 << k) - 9'd1);
      step(1'b0, v, 2);
    end
    step(1'b0, 8'hFF, 2);
    step(1'b0, 8'hEF, 2);
    for (int k = 0; k < 3000; k++) step(1'b0, 8'($urandom), 2);
    step(1'b0, 8'hFF, 2);
    step(1'b1, 8'hFF, 1);
    step(1'b0, 8'hFF, 2);
    step(1'b0, 8'h00, 1);
    for (int k = 0; k < 5 && sb.size() != 0; k++) @(posedge clk);
    #2;
    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL drain: %0d entries left, required 0", sb.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
